// File: rtl/burst_rx_checker_if.sv
// Valid/ready bundle seen by the receive-side checker: the snooped TX handshake plus the RX port
// of the pipe under test.
interface burst_rx_checker_if #(
    parameter int DW = 32
);
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_ready;

    modport master (
        output tx_valid, tx_ready, tx_data, rx_valid, rx_data,
        input  rx_ready
    );

    modport slave (
        input  tx_valid, tx_ready, tx_data, rx_valid, rx_data,
        output rx_ready
    );
endinterface

// File: rtl/burst_rx_checker.sv
// Receive-side burst checker: applies a backpressure pattern, queues (data+4)*5 for every TX
// handshake and scores each RX beat against the queue head, grouped into BURST_LEN-beat bursts.
module burst_rx_checker #(
    parameter int DW         = 32,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rstn_dff,
    burst_rx_checker_if.slave bus_if,
    input  logic [7:0]        bp_pattern_i,
    output logic              burst_done_o,
    output logic [7:0]        match_cnt_o,
    output logic [7:0]        mismatch_cnt_o,
    output logic [7:0]        burst_cnt_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              pass_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_LEN);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t        state_q;
    logic [BW-1:0] beat_cnt_q;
    logic [2:0]    phase_q;
    logic          rx_ready_q, burst_done_q, overflow_q, underflow_q, pass_q;
    logic [7:0]    match_cnt_q, mismatch_cnt_q, burst_cnt_q;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          push_req, fifo_full, fifo_empty, push, accept, pop, hit, last_beat;
    logic [DW-1:0] golden, head;
    logic [7:0]    match_cnt_d, mismatch_cnt_d, burst_cnt_d;
    logic          overflow_d, underflow_d, idle_d, pass_d;
    logic [CW-1:0] count_d;

    assign push_req   = bus_if.tx_valid && bus_if.tx_ready;
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = push_req && !fifo_full;
    assign accept     = bus_if.rx_valid && rx_ready_q;
    assign pop        = accept && !fifo_empty;
    assign golden     = (bus_if.tx_data + DW'(4)) * DW'(5);
    assign head       = mem_q[rd_ptr_q];
    assign hit        = pop && (bus_if.rx_data == head);
    assign last_beat  = (state_q == BURST) && (beat_cnt_q == BW'(BURST_LEN - 1));

    // An accept against an empty FIFO never sees a same-cycle push, so it scores as underflow.
    always_comb begin
        match_cnt_d    = hit ? sat_inc(match_cnt_q) : match_cnt_q;
        mismatch_cnt_d = (accept && !hit) ? sat_inc(mismatch_cnt_q) : mismatch_cnt_q;
        burst_cnt_d    = (accept && last_beat) ? sat_inc(burst_cnt_q) : burst_cnt_q;
        overflow_d     = overflow_q || (push_req && fifo_full);
        underflow_d    = underflow_q || (accept && fifo_empty);
        count_d        = count_q + CW'(push) - CW'(pop);
        idle_d         = accept ? last_beat : (state_q == IDLE);
        pass_d         = (burst_cnt_d != 8'd0) && (mismatch_cnt_d == 8'd0) && !overflow_d &&
                         !underflow_d && (count_d == '0) && idle_d;
    end

    always_ff @(posedge clk or negedge rstn_dff) begin
        if (!rstn_dff) begin
            state_q        <= IDLE;
            beat_cnt_q     <= '0;
            phase_q        <= 3'd0;
            rx_ready_q     <= 1'b0;
            burst_done_q   <= 1'b0;
            match_cnt_q    <= 8'd0;
            mismatch_cnt_q <= 8'd0;
            burst_cnt_q    <= 8'd0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            pass_q         <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            phase_q        <= phase_q + 3'd1;
            rx_ready_q     <= bp_pattern_i[phase_q];
            burst_done_q   <= 1'b0;
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            burst_cnt_q    <= burst_cnt_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            pass_q         <= pass_d;
            count_q        <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        beat_cnt_q <= BW'(1);
                        state_q    <= BURST;
                    end
                    BURST: begin
                        if (last_beat) begin
                            beat_cnt_q   <= '0;
                            state_q      <= IDLE;
                            burst_done_q <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Golden storage holds data only; occupancy and pointers above define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= golden;
    end

    assign bus_if.rx_ready = rx_ready_q;
    assign burst_done_o    = burst_done_q;
    assign match_cnt_o     = match_cnt_q;
    assign mismatch_cnt_o  = mismatch_cnt_q;
    assign burst_cnt_o     = burst_cnt_q;
    assign overflow_o      = overflow_q;
    assign underflow_o     = underflow_q;
    assign pass_o          = pass_q;
endmodule

// File: tb/tb_burst_rx_checker.sv
// Bench for burst_rx_checker: directed scenarios plus randomized traffic, every cycle scored
// against a queue-based reference model of the checker's rules.
module tb_burst_rx_checker;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int FD = 8;

    logic       clk = 1'b0;
    logic       rstn_dff = 1'b0;
    logic [7:0] bp = 8'h00;
    logic       burst_done, overflow, underflow, pass;
    logic [7:0] match_cnt, mismatch_cnt, burst_cnt;

    burst_rx_checker_if #(.DW(DW)) bus ();

    burst_rx_checker #(.DW(DW), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .rstn_dff       (rstn_dff),
        .bus_if         (bus),
        .bp_pattern_i   (bp),
        .burst_done_o   (burst_done),
        .match_cnt_o    (match_cnt),
        .mismatch_cnt_o (mismatch_cnt),
        .burst_cnt_o    (burst_cnt),
        .overflow_o     (overflow),
        .underflow_o    (underflow),
        .pass_o         (pass)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] gold(input logic [31:0] d);
        return (d + 32'd4) * 32'd5;
    endfunction

    // Reference model: golden queue, plain counters, beats-into-burst count.
    logic [31:0] m_q[$];
    int          m_phase, m_mat, m_mis, m_bur, m_beats;
    bit          m_ready, m_done, m_ovf, m_unf, m_pass;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_phase = 0; m_mat = 0; m_mis = 0; m_bur = 0; m_beats = 0;
        m_ready = 0; m_done = 0; m_ovf = 0; m_unf = 0; m_pass = 0;
    endtask

    task automatic model_step();
        bit acc, psh;
        int occ;
        acc    = bus.rx_valid && m_ready;
        psh    = bus.tx_valid && bus.tx_ready;
        occ    = m_q.size();
        m_done = 0;
        if (acc) begin
            if (occ == 0) begin
                m_unf = 1;
                m_mis = sat(m_mis + 1);
            end else if (bus.rx_data == m_q[0]) begin
                m_mat = sat(m_mat + 1);
            end else begin
                m_mis = sat(m_mis + 1);
            end
            m_beats++;
            if (m_beats == BL) begin
                m_beats = 0;
                m_bur   = sat(m_bur + 1);
                m_done  = 1;
            end
            if (occ > 0) void'(m_q.pop_front());
        end
        if (psh) begin
            if (occ == FD) m_ovf = 1;
            else m_q.push_back(gold(bus.tx_data));
        end
        m_ready = bp[m_phase];
        m_phase = (m_phase + 1) % 8;
        m_pass  = (m_bur != 0) && (m_mis == 0) && !m_ovf && !m_unf && (m_q.size() == 0) && (m_beats == 0);
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".rx_ready"}, bus.rx_ready, m_ready);
        check_eq({tag, ".burst_done"}, burst_done, m_done);
        check_eq({tag, ".match"}, match_cnt, m_mat);
        check_eq({tag, ".mismatch"}, mismatch_cnt, m_mis);
        check_eq({tag, ".bursts"}, burst_cnt, m_bur);
        check_eq({tag, ".overflow"}, overflow, m_ovf);
        check_eq({tag, ".underflow"}, underflow, m_unf);
        check_eq({tag, ".pass"}, pass, m_pass);
    endtask

    // Pipe emulation: TX words waiting to be handed over, RX words the pipe will return.
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    bit          auto_rx = 0;
    int          n_done = 0;

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rstn_dff = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_ready = 1'b0; bus.rx_valid = 1'b0;
        tx_q.delete(); rx_q.delete();
        model_reset();
        n_done = 0;
        #1;
        check_all(tag);
        @(negedge clk);
        rstn_dff = 1'b1;
    endtask

    task automatic cycle(input string tag, input int tx_pct, input int rx_pct, input int bad_pct);
        bit          tx_hs, rx_hs;
        logic [31:0] d;
        if (auto_rx && tx_q.size() == 0 && $urandom_range(99) < 70)
            tx_q.push_back(($urandom_range(15) == 0) ? 32'hFFFF_FFFF : $urandom);
        bus.tx_valid = (tx_q.size() > 0);
        bus.tx_data  = bus.tx_valid ? tx_q[0] : $urandom;
        bus.tx_ready = ($urandom_range(99) < tx_pct);
        if (!bus.rx_valid && rx_q.size() > 0 && $urandom_range(99) < rx_pct) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = rx_q[0];
        end
        tx_hs = bus.tx_valid && bus.tx_ready;
        rx_hs = bus.rx_valid && bus.rx_ready;
        model_step();
        @(posedge clk);
        #1;
        if (tx_hs) begin
            d = tx_q.pop_front();
            if (auto_rx) rx_q.push_back(($urandom_range(99) < bad_pct) ? (gold(d) ^ 32'h1) : gold(d));
        end
        if (auto_rx && bad_pct > 50 && $urandom_range(99) == 0) rx_q.push_back($urandom);
        if (rx_hs) begin
            void'(rx_q.pop_front());
            bus.rx_valid = 1'b0;
        end
        if (burst_done) n_done++;
        check_all(tag);
    endtask

    task automatic run_burst(input string tag, input logic [7:0] pat, input logic [31:0] rx3);
        apply_reset({tag, ".rst"});
        bp = pat;
        tx_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        rx_q = '{32'h19, 32'h1E, rx3, 32'h28};
        repeat (5) cycle({tag, ".tx"}, 100, 0, 0);
        repeat (16) cycle({tag, ".rx"}, 100, 100, 0);
    endtask

    initial begin
        bus.tx_valid = 1'b0; bus.tx_ready = 1'b0; bus.tx_data = '0;
        bus.rx_valid = 1'b0; bus.rx_data = '0;
        model_reset();

        // Clean burst, always ready.
        run_burst("t1", 8'hFF, 32'h23);
        check_eq("t1.match_final", match_cnt, 32'd4);
        check_eq("t1.done_pulses", n_done, 32'd1);
        check_eq("t1.bursts_final", burst_cnt, 32'd1);
        check_eq("t1.pass_final", pass, 32'd1);

        // Alternating backpressure.
        run_burst("t2", 8'hAA, 32'h23);
        check_eq("t2.match_final", match_cnt, 32'd4);
        check_eq("t2.pass_final", pass, 32'd1);

        // One corrupted beat.
        apply_reset("t3.rst");
        bp = 8'hFF;
        tx_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        rx_q = '{32'h19, 32'h1F, 32'h23, 32'h28};
        repeat (5) cycle("t3.tx", 100, 0, 0);
        repeat (10) cycle("t3.rx", 100, 100, 0);
        check_eq("t3.match_final", match_cnt, 32'd3);
        check_eq("t3.mismatch_final", mismatch_cnt, 32'd1);
        check_eq("t3.bursts_final", burst_cnt, 32'd1);
        check_eq("t3.pass_final", pass, 32'd0);

        // RX before any TX.
        apply_reset("t4.rst");
        bp = 8'hFF;
        rx_q = '{32'h19};
        repeat (4) cycle("t4", 100, 100, 0);
        check_eq("t4.underflow_final", underflow, 32'd1);
        check_eq("t4.mismatch_final", mismatch_cnt, 32'd1);
        check_eq("t4.pass_final", pass, 32'd0);

        // Nine pushes into an eight-deep FIFO, then drain.
        apply_reset("t5.rst");
        bp = 8'h00;
        for (int i = 1; i <= 9; i++) tx_q.push_back(i);
        repeat (8) cycle("t5.fill", 100, 0, 0);
        check_eq("t5.ovf_after8", overflow, 32'd0);
        cycle("t5.ninth", 100, 0, 0);
        check_eq("t5.ovf_after9", overflow, 32'd1);
        bp = 8'hFF;
        for (int i = 1; i <= 8; i++) rx_q.push_back(gold(i));
        repeat (12) cycle("t5.drain", 100, 100, 0);
        check_eq("t5.match_final", match_cnt, 32'd8);
        check_eq("t5.bursts_final", burst_cnt, 32'd2);
        check_eq("t5.pass_final", pass, 32'd0);

        // Wrapping golden value, then reset inside a partial burst.
        apply_reset("t6.rst");
        bp = 8'hFF;
        tx_q = '{32'hFFFF_FFFF};
        rx_q = '{32'h0000_000F};
        repeat (2) cycle("t6.tx", 100, 0, 0);
        repeat (3) cycle("t6.rx", 100, 100, 0);
        check_eq("t6.wrap_match", match_cnt, 32'd1);
        tx_q = '{32'd1, 32'd2};
        rx_q = '{32'h19, 32'h1E};
        repeat (3) cycle("t6.tx2", 100, 0, 0);
        repeat (4) cycle("t6.rx2", 100, 100, 0);
        check_eq("t6.partial_bursts", burst_cnt, 32'd0);
        apply_reset("t6.midrst");
        check_eq("t6.rst_match", match_cnt, 32'd0);
        bp = 8'hFF;
        tx_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        rx_q = '{32'h19, 32'h1E, 32'h23, 32'h28};
        repeat (5) cycle("t6.tx3", 100, 0, 0);
        repeat (8) cycle("t6.rx3", 100, 100, 0);
        check_eq("t6.after_rst_bursts", burst_cnt, 32'd1);
        check_eq("t6.after_rst_pass", pass, 32'd1);

        // Randomized traffic: clean, lightly corrupted, then heavily corrupted with stray beats.
        apply_reset("rnd.rst");
        auto_rx = 1;
        for (int seg = 0; seg < 32; seg++) begin
            bp = (seg < 10) ? 8'hFF : 8'($urandom);
            repeat (100) cycle("rnd", (seg < 10) ? 30 : 60, 70, (seg < 10) ? 0 : ((seg < 20) ? 5 : 80));
        end
        auto_rx = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
